// File: rtl/pipo_reg_pkg.sv
// Shared defaults for the small storage registers in the datapath.
// Latency: none (constants only).
// Backpressure: none (constants only).
`timescale 1ns/1ps
package pipo_reg_pkg;

    // Default width shared by the holding/staging registers beside the shift registers.
    localparam int PIPO_DEF_WIDTH = 4;

endpackage : pipo_reg_pkg

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out holding register: captures dIn when load is high, else holds.
// Latency: one cycle from a load edge to dOut; dOut is driven straight from the flops.
// Backpressure: none; the block is always ready and has no handshake or status outputs.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   nRst  - synchronous active-low reset, loads RST_VAL and overrides load
//   load  - parallel-load enable, sampled on the rising edge
//   dIn   - WIDTH-bit parallel data input
//   dOut  - WIDTH-bit registered parallel data output
`timescale 1ns/1ps
module pipo_reg
    import pipo_reg_pkg::*;
#(
    parameter int               WIDTH   = PIPO_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             load,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH-1:0] dOut
);

    // Reset is sampled only on the clock edge, so a low pulse between edges is
    // invisible, and reset wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            dOut <= RST_VAL;
        end else if (load) begin
            dOut <= dIn;
        end
    end

endmodule : pipo_reg

// File: tb/tb_pipo_reg.sv
// Directed bench for pipo_reg: 200 ns clock, rising edges at 100, 300, 500 ns ...
// Stimulus follows an absolute timeline; outputs are sampled between edges.
// Each scenario task carries its own inline comparisons.
`timescale 1ns/1ps
module tb_pipo_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             nRst;
    logic             load;
    logic [WIDTH-1:0] dIn;
    logic [WIDTH-1:0] dOut;

    int checks;
    int errors;

    pipo_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .load (load),
        .dIn  (dIn),
        .dOut (dOut)
    );

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    // Advance to an absolute simulation time in ns.
    task automatic waitUntil(input time t);
        if ($time < t) #(t - $time);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        load = 1'b0;
        dIn  = '0;
        waitUntil(150);
        checks++;
        if (dOut !== 4'd0) begin
            errors++;
            $display("FAIL reset_edge100 got %0h expected %0h", dOut, 4'd0);
        end
        waitUntil(200);
        nRst = 1'b1;
    endtask

    task automatic test_load();
        waitUntil(250);
        dIn = 4'd15;
        waitUntil(340);
        // Edge at 300 ns had nRst high and load low: value from reset is held.
        checks++;
        if (dOut !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold_edge300 got %0h expected %0h", dOut, 4'd0);
        end
        waitUntil(350);
        load = 1'b1;
        waitUntil(450);
        // load rose after the 300 ns edge, so nothing captured yet.
        checks++;
        if (dOut !== 4'd0) begin
            errors++;
            $display("FAIL load_not_yet got %0h expected %0h", dOut, 4'd0);
        end
        waitUntil(550);
        load = 1'b0;
        waitUntil(600);
        checks++;
        if (dOut !== 4'd15) begin
            errors++;
            $display("FAIL load_edge500 got %0h expected %0h", dOut, 4'd15);
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 4'd10;
        vals[1] = 4'd5;
        vals[2] = 4'd13;
        vals[3] = 4'd9;
        for (int i = 0; i < 4; i++) begin
            waitUntil(time'(750 + 200 * i));
            dIn = vals[i];
            waitUntil(time'(950 + 200 * i));
            checks++;
            if (dOut !== 4'd15) begin
                errors++;
                $display("FAIL hold_step%0d got %0h expected %0h", i, dOut, 4'd15);
            end
        end
    endtask

    task automatic test_late_load();
        waitUntil(1550);
        dIn = 4'd7;
        waitUntil(1650);
        load = 1'b1;
        waitUntil(1750);
        checks++;
        if (dOut !== 4'd7) begin
            errors++;
            $display("FAIL late_load_edge1700 got %0h expected %0h", dOut, 4'd7);
        end
        waitUntil(1800);
        dIn = 4'd14;
        waitUntil(1850);
        load = 1'b0;
        waitUntil(1950);
        checks++;
        if (dOut !== 4'd7) begin
            errors++;
            $display("FAIL late_load_no14 got %0h expected %0h", dOut, 4'd7);
        end
        waitUntil(2050);
        dIn = 4'd3;
        waitUntil(2150);
        checks++;
        if (dOut !== 4'd7) begin
            errors++;
            $display("FAIL late_load_no3 got %0h expected %0h", dOut, 4'd7);
        end
    endtask

    task automatic test_reset_priority();
        waitUntil(2150);
        nRst = 1'b0;
        load = 1'b1;
        dIn  = 4'd9;
        waitUntil(2250);
        // No asynchronous clear: value survives until the 2300 ns edge.
        checks++;
        if (dOut !== 4'd7) begin
            errors++;
            $display("FAIL reset_not_async got %0h expected %0h", dOut, 4'd7);
        end
        waitUntil(2350);
        checks++;
        if (dOut !== 4'd0) begin
            errors++;
            $display("FAIL reset_over_load got %0h expected %0h", dOut, 4'd0);
        end
        nRst = 1'b1;
        load = 1'b0;
    endtask

    task automatic test_sync_reset();
        waitUntil(2350);
        load = 1'b1;
        dIn  = 4'd5;
        waitUntil(2550);
        load = 1'b0;
        waitUntil(2600);
        checks++;
        if (dOut !== 4'd5) begin
            errors++;
            $display("FAIL preload5 got %0h expected %0h", dOut, 4'd5);
        end
        // Reset pulse strictly between the 2500 and 2700 ns edges.
        waitUntil(2625);
        nRst = 1'b0;
        waitUntil(2675);
        nRst = 1'b1;
        waitUntil(2750);
        checks++;
        if (dOut !== 4'd5) begin
            errors++;
            $display("FAIL reset_pulse_between_edges got %0h expected %0h", dOut, 4'd5);
        end
        // Load glitch between the 2700 and 2900 ns edges.
        waitUntil(2760);
        load = 1'b1;
        dIn  = 4'd12;
        waitUntil(2790);
        load = 1'b0;
        waitUntil(2950);
        checks++;
        if (dOut !== 4'd5) begin
            errors++;
            $display("FAIL load_glitch got %0h expected %0h", dOut, 4'd5);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 4'd1;
        vals[1] = 4'd2;
        vals[2] = 4'd3;
        waitUntil(2950);
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waitUntil(time'(2950 + 200 * i));
            dIn = vals[i];
            waitUntil(time'(3150 + 200 * i));
            checks++;
            if (dOut !== vals[i]) begin
                errors++;
                $display("FAIL b2b_load%0d got %0h expected %0h", i, dOut, vals[i]);
            end
        end
        // Undriven input while not loading must not disturb dOut.
        load = 1'b0;
        dIn  = 'x;
        waitUntil(3750);
        checks++;
        if (dOut !== 4'd3) begin
            errors++;
            $display("FAIL x_input_hold got %0h expected %0h", dOut, 4'd3);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load();
        test_hold();
        test_late_load();
        test_reset_priority();
        test_sync_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipo_reg
